// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative cache: FSM states and line/address geometry.
package cache_pkg;

    typedef enum logic [1:0] {
        ST_COMPARE   = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2,
        ST_REFILL    = 2'd3
    } state_t;

    localparam int LINE_W         = 128;
    localparam int WORDS_PER_LINE = 4;
    localparam int WORD_W         = 32;
    localparam int ADDR_W         = 30;
    localparam int LINE_ADDR_W    = 28;
    localparam int OFFSET_W       = $clog2(WORDS_PER_LINE);

endpackage

// File: rtl/cache_lru.sv
// True-LRU replacement: per-set age ranks (0 = most recent), victim select and rank update.
module cache_lru #(
    parameter int SETS = 8,
    parameter int WAYS = 2
) (
    input  logic                                    clk,
    input  logic                                    proc_reset,
    input  logic [$clog2(SETS)-1:0]                 i_set,
    input  logic [WAYS-1:0]                         i_valid,
    input  logic                                    i_update,
    input  logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0] i_way,
    output logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0] o_victim
);
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic [WAY_W-1:0] r_rank [SETS][WAYS];

    // Ways younger than the touched way age by one; the touched way becomes youngest.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    r_rank[s][w] <= WAY_W'(w);
        end else if (i_update) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == i_way)
                    r_rank[i_set][w] <= '0;
                else if (r_rank[i_set][w] < r_rank[i_set][i_way])
                    r_rank[i_set][w] <= r_rank[i_set][w] + 1'b1;
            end
        end
    end

    // Lowest-numbered invalid way wins over the oldest way.
    always_comb begin
        o_victim = '0;
        for (int w = 0; w < WAYS; w++)
            if (r_rank[i_set][w] == WAY_W'(WAYS - 1))
                o_victim = WAY_W'(w);
        for (int w = WAYS - 1; w >= 0; w--)
            if (!i_valid[w])
                o_victim = WAY_W'(w);
    end

endmodule

// File: rtl/cache_sa.sv
// Write-back, write-allocate set-associative cache with 4-word lines and hit/miss counters.
module cache_sa
    import cache_pkg::*;
#(
    parameter int SETS = 8,
    parameter int WAYS = 2
) (
    input  logic                   clk,
    input  logic                   proc_reset,
    input  logic                   proc_read,
    input  logic                   proc_write,
    input  logic [ADDR_W-1:0]      proc_addr,
    input  logic [WORD_W-1:0]      proc_wdata,
    output logic                   proc_stall,
    output logic [WORD_W-1:0]      proc_rdata,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [LINE_ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0]      mem_wdata,
    input  logic [LINE_W-1:0]      mem_rdata,
    input  logic                   mem_ready,
    output logic [15:0]            hit_cnt,
    output logic [15:0]            miss_cnt
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = LINE_ADDR_W - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    state_t             r_state, w_next;
    logic [SETS-1:0]    r_valid [WAYS];
    logic [SETS-1:0]    r_dirty [WAYS];
    logic [TAG_W-1:0]   r_tag   [WAYS][SETS];
    logic [LINE_W-1:0]  r_data  [WAYS][SETS];
    logic [LINE_W-1:0]  r_line;
    logic [WAY_W-1:0]   r_victim;
    logic               r_after_miss;
    logic [15:0]        r_hit_cnt, r_miss_cnt;

    logic [IDX_W-1:0]    w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic [OFFSET_W-1:0] w_word;
    logic [WAYS-1:0]     w_way_hit, w_valid_set;
    logic                w_req, w_hit, w_done, w_miss, w_victim_dirty, w_lru_update;
    logic [WAY_W-1:0]    w_hit_way, w_victim, w_lru_way;
    logic [LINE_W-1:0]   w_hit_line;

    assign w_idx  = proc_addr[IDX_W+OFFSET_W-1:OFFSET_W];
    assign w_tag  = proc_addr[ADDR_W-1:IDX_W+OFFSET_W];
    assign w_word = proc_addr[OFFSET_W-1:0];
    assign w_req  = proc_read | proc_write;

    always_comb begin
        w_way_hit   = '0;
        w_valid_set = '0;
        w_hit       = 1'b0;
        w_hit_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            w_valid_set[w] = r_valid[w][w_idx];
            w_way_hit[w]   = r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag);
        end
        for (int w = WAYS - 1; w >= 0; w--)
            if (w_way_hit[w]) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
    end

    assign w_hit_line     = r_data[w_hit_way][w_idx];
    assign w_done         = (r_state == ST_COMPARE) && w_req && w_hit;
    assign w_miss         = (r_state == ST_COMPARE) && w_req && !w_hit;
    assign w_victim_dirty = r_dirty[w_victim][w_idx];
    assign w_lru_update   = w_done || (r_state == ST_REFILL);
    assign w_lru_way      = (r_state == ST_REFILL) ? r_victim : w_hit_way;

    cache_lru #(.SETS(SETS), .WAYS(WAYS)) u_lru (
        .clk        (clk),
        .proc_reset (proc_reset),
        .i_set      (w_idx),
        .i_valid    (w_valid_set),
        .i_update   (w_lru_update),
        .i_way      (w_lru_way),
        .o_victim   (w_victim)
    );

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) r_state <= ST_COMPARE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_COMPARE:   if (w_miss) w_next = w_victim_dirty ? ST_WRITEBACK : ST_ALLOCATE;
            ST_WRITEBACK: if (mem_ready) w_next = ST_ALLOCATE;
            ST_ALLOCATE:  if (mem_ready) w_next = ST_REFILL;
            ST_REFILL:    w_next = ST_COMPARE;
            default:      w_next = ST_COMPARE;
        endcase
    end

    always_comb begin
        proc_stall = 1'b0;
        proc_rdata = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (r_state)
            ST_COMPARE: begin
                proc_stall = w_miss;
                if (w_done && proc_read && !proc_write)
                    proc_rdata = w_hit_line[WORD_W*w_word +: WORD_W];
            end
            ST_WRITEBACK: begin
                proc_stall = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = {r_tag[r_victim][w_idx], w_idx};
                mem_wdata  = r_data[r_victim][w_idx];
            end
            ST_ALLOCATE: begin
                proc_stall = 1'b1;
                mem_read   = 1'b1;
                mem_addr   = proc_addr[ADDR_W-1:OFFSET_W];
            end
            ST_REFILL: proc_stall = 1'b1;
            default: ;
        endcase
    end

    // The victim is frozen at miss time so the refill targets the way that was written back.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            r_victim <= '0;
            for (int w = 0; w < WAYS; w++) begin
                r_valid[w] <= '0;
                r_dirty[w] <= '0;
            end
        end else begin
            if (w_miss) r_victim <= w_victim;
            if (r_state == ST_REFILL) begin
                r_valid[r_victim][w_idx] <= 1'b1;
                r_dirty[r_victim][w_idx] <= 1'b0;
            end else if (w_done && proc_write) begin
                r_dirty[w_hit_way][w_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_ALLOCATE && mem_ready) r_line <= mem_rdata;
        if (r_state == ST_REFILL) begin
            r_data[r_victim][w_idx] <= r_line;
            r_tag[r_victim][w_idx]  <= w_tag;
        end else if (w_done && proc_write) begin
            r_data[w_hit_way][w_idx][WORD_W*w_word +: WORD_W] <= proc_wdata;
        end
    end

    // The hit that completes a refilled request belongs to the miss, not the hit count.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            r_after_miss <= 1'b0;
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
        end else if (w_miss) begin
            r_after_miss <= 1'b1;
            if (r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
        end else if (w_done) begin
            if (r_after_miss)                r_after_miss <= 1'b0;
            else if (r_hit_cnt != 16'hFFFF) r_hit_cnt    <= r_hit_cnt + 16'd1;
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;

endmodule

// File: tb/tb_cache_sa.sv
// Directed bench for cache_sa (SETS=8, WAYS=2): vector table plus reset and saturation sequences.
module tb_cache_sa;

    logic         clk = 1'b0;
    logic         proc_reset, proc_read, proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata, proc_rdata;
    logic         proc_stall, mem_read, mem_write, mem_ready;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
    logic [15:0]  hit_cnt, miss_cnt;

    int checks = 0;
    int errors = 0;

    logic [127:0] mem_q [logic [27:0]];

    cache_sa #(.SETS(8), .WAYS(2)) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_stall (proc_stall),
        .proc_rdata (proc_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    always #5 clk = ~clk;

    // Untouched memory lines hold word k = 32'hA000_0000 | {line_addr, 4'h0} | k.
    function automatic logic [127:0] pat(input logic [27:0] a);
        logic [31:0] b;
        b = 32'hA000_0000 | {a, 4'h0};
        return {b | 32'd3, b | 32'd2, b | 32'd1, b};
    endfunction

    function automatic logic [127:0] mem_line(input logic [27:0] a);
        if (mem_q.exists(a)) return mem_q[a];
        return pat(a);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One processor request, serving memory transactions until the cache stops stalling.
    task automatic access(input bit rd, input bit wr, input logic [29:0] a, input logic [31:0] d,
                          output logic [31:0] rdata, output bit missed, output bit wb,
                          output logic [27:0] wb_a, output logic [27:0] rd_a,
                          output int lat, output bit timed_out);
        bit filled;
        rdata = '0; missed = 0; wb = 0; wb_a = '0; rd_a = '0; lat = 0; timed_out = 1; filled = 0;
        @(negedge clk);
        proc_read = rd; proc_write = wr; proc_addr = a; proc_wdata = d;
        for (int cyc = 0; cyc < 60; cyc++) begin
            #1;
            if (!proc_stall) begin
                rdata = proc_rdata;
                timed_out = 0;
                break;
            end
            if (mem_write) begin
                wb = 1; wb_a = mem_addr; mem_q[mem_addr] = mem_wdata; mem_ready = 1;
            end else if (mem_read) begin
                missed = 1; rd_a = mem_addr; mem_rdata = mem_line(mem_addr); mem_ready = 1; filled = 1;
            end
            @(posedge clk);
            #1 mem_ready = 0;
            @(negedge clk);
            if (filled) lat++;
        end
        @(posedge clk);
        #1 proc_read = 0; proc_write = 0;
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_miss;
        bit          exp_wb;
        logic [27:0] exp_wb_addr;
        logic [27:0] exp_rd_addr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rd, bit wr, logic [29:0] a, logic [31:0] d, logic [31:0] er,
                                bit em, bit ew, logic [27:0] ewa, logic [27:0] era);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = a; v.wdata = d; v.exp_rdata = er;
        v.exp_miss = em; v.exp_wb = ew; v.exp_wb_addr = ewa; v.exp_rd_addr = era;
        return v;
    endfunction

    initial begin
        logic [31:0] rdata;
        bit          missed, wb, to;
        logic [27:0] wb_a, rd_a;
        int          lat, exp_hits, exp_misses;

        //            rd wr addr      wdata         exp_rdata     miss wb wb_a    rd_a
        vecs.push_back(mk(1, 0, 30'h04, 32'h0,        32'hAAAAAAAA, 1, 0, 28'h0,  28'h01));
        vecs.push_back(mk(0, 1, 30'h04, 32'hCAFEF00D, 32'h0,        0, 0, 28'h0,  28'h00));
        vecs.push_back(mk(1, 0, 30'h04, 32'h0,        32'hCAFEF00D, 0, 0, 28'h0,  28'h00));
        vecs.push_back(mk(1, 0, 30'h24, 32'h0,        32'hA0000090, 1, 0, 28'h0,  28'h09));
        vecs.push_back(mk(1, 0, 30'h04, 32'h0,        32'hCAFEF00D, 0, 0, 28'h0,  28'h00));
        vecs.push_back(mk(1, 0, 30'h44, 32'h0,        32'hA0000110, 1, 0, 28'h0,  28'h11));
        vecs.push_back(mk(1, 0, 30'h04, 32'h0,        32'hCAFEF00D, 0, 0, 28'h0,  28'h00));
        vecs.push_back(mk(0, 1, 30'h25, 32'h12345678, 32'h0,        1, 0, 28'h0,  28'h09));
        vecs.push_back(mk(1, 0, 30'h25, 32'h0,        32'h12345678, 0, 0, 28'h0,  28'h00));
        vecs.push_back(mk(1, 0, 30'h04, 32'h0,        32'hCAFEF00D, 0, 0, 28'h0,  28'h00));
        vecs.push_back(mk(1, 0, 30'h46, 32'h0,        32'hA0000112, 1, 1, 28'h09, 28'h11));
        vecs.push_back(mk(1, 0, 30'h24, 32'h0,        32'hA0000090, 1, 1, 28'h01, 28'h09));
        vecs.push_back(mk(1, 0, 30'h25, 32'h0,        32'h12345678, 0, 0, 28'h0,  28'h00));
        vecs.push_back(mk(1, 0, 30'h04, 32'h0,        32'hCAFEF00D, 1, 0, 28'h0,  28'h01));
        vecs.push_back(mk(1, 1, 30'h05, 32'h0BADBEEF, 32'h0,        0, 0, 28'h0,  28'h00));
        vecs.push_back(mk(1, 0, 30'h05, 32'h0,        32'h0BADBEEF, 0, 0, 28'h0,  28'h00));
        vecs.push_back(mk(1, 0, 30'h08, 32'h0,        32'hA0000020, 1, 0, 28'h0,  28'h02));
        vecs.push_back(mk(0, 1, 30'h00, 32'h55AA55AA, 32'h0,        1, 0, 28'h0,  28'h00));
        vecs.push_back(mk(1, 0, 30'h00, 32'h0,        32'h55AA55AA, 0, 0, 28'h0,  28'h00));
        vecs.push_back(mk(1, 0, 30'h03, 32'h0,        32'hA0000003, 0, 0, 28'h0,  28'h00));

        mem_q[28'h1] = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;

        // Reset state
        proc_reset = 1; proc_read = 0; proc_write = 0; proc_addr = '0; proc_wdata = '0;
        mem_ready = 0; mem_rdata = '0;
        #1;
        check("rst_stall", proc_stall, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);
        check("rst_rdata", proc_rdata, 0);
        @(negedge clk);
        @(negedge clk);
        proc_reset = 0;

        exp_hits = 0; exp_misses = 0;
        foreach (vecs[i]) begin
            access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rdata, missed, wb, wb_a, rd_a, lat, to);
            check($sformatf("v%0d_timeout", i), to, 0);
            check($sformatf("v%0d_miss", i), missed, vecs[i].exp_miss);
            check($sformatf("v%0d_wb", i), wb, vecs[i].exp_wb);
            if (vecs[i].exp_miss) begin
                exp_misses++;
                check($sformatf("v%0d_rd_addr", i), rd_a, vecs[i].exp_rd_addr);
                check($sformatf("v%0d_fill_lat", i), lat, 2);
            end else begin
                exp_hits++;
            end
            if (vecs[i].exp_wb) check($sformatf("v%0d_wb_addr", i), wb_a, vecs[i].exp_wb_addr);
            if (vecs[i].rd && !vecs[i].wr) check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d_hit_cnt", i), hit_cnt, exp_hits);
            check($sformatf("v%0d_miss_cnt", i), miss_cnt, exp_misses);
        end

        // Idle: no request
        @(negedge clk);
        #1;
        check("idle_stall", proc_stall, 0);
        check("idle_rdata", proc_rdata, 0);
        check("idle_mem_addr", mem_addr, 0);

        // Reset in ALLOCATE with mem_ready low
        @(negedge clk);
        proc_read = 1; proc_addr = 30'h88;
        missed = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (mem_read) begin
                missed = 1;
                break;
            end
            @(negedge clk);
        end
        check("alloc_reached", missed, 1);
        #2 proc_reset = 1;
        #1;
        check("async_mem_read", mem_read, 0);
        check("async_mem_write", mem_write, 0);
        check("async_hit_cnt", hit_cnt, 0);
        check("async_miss_cnt", miss_cnt, 0);
        proc_read = 0;
        @(negedge clk);
        proc_reset = 0;
        // Dirty word 0BADBEEF was discarded; memory still holds BBBBBBBB in word 1 of line 1
        access(1, 0, 30'h05, 32'h0, rdata, missed, wb, wb_a, rd_a, lat, to);
        check("post_rst_timeout", to, 0);
        check("post_rst_miss", missed, 1);
        check("post_rst_wb", wb, 0);
        check("post_rst_rdata", rdata, 32'hBBBBBBBB);
        check("post_rst_miss_cnt", miss_cnt, 1);
        check("post_rst_hit_cnt", hit_cnt, 0);

        // Hit counter saturation
        @(negedge clk);
        proc_read = 1; proc_addr = 30'h05;
        #1;
        check("sat_hit_stall", proc_stall, 0);
        check("sat_hit_rdata", proc_rdata, 32'hBBBBBBBB);
        repeat (65540) @(posedge clk);
        #1 proc_read = 0;
        @(negedge clk);
        check("sat_hit_cnt", hit_cnt, 16'hFFFF);
        check("sat_miss_cnt", miss_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_sa.md
CACHE_SA -- requirements
Module: cache_sa

Interface
REQ-001 SHALL have parameter SETS, default 8: sets per way, power of two, 2..64.
REQ-002 SHALL have parameter WAYS, default 2: associativity, one of 1, 2, 4.
REQ-003 SHALL have port clk, input, 1: clock, rising edge.
REQ-004 SHALL have port proc_reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port proc_read, input, 1: processor read request.
REQ-006 SHALL have port proc_write, input, 1: processor write request.
REQ-007 SHALL have port proc_addr, input, 30: word address; [1:0] word-in-line, [log2(SETS)+1:2] index, rest tag.
REQ-008 SHALL have port proc_wdata, input, 32: write data.
REQ-009 SHALL have port proc_stall, output, 1: request not yet completed.
REQ-010 SHALL have port proc_rdata, output, 32: read data, valid when proc_read=1 and proc_stall=0.
REQ-011 SHALL have ports mem_read and mem_write, output, 1 each: memory line read and line write strobes.
REQ-012 SHALL have port mem_addr, output, 28: line address.
REQ-013 SHALL have port mem_wdata, output, 128: write-back line.
REQ-014 SHALL have port mem_rdata, input, 128: refill line.
REQ-015 SHALL have port mem_ready, input, 1: memory transaction complete.
REQ-016 SHALL have ports hit_cnt and miss_cnt, output, 16 each: saturating access counters.

Function
REQ-017 SHALL be a WAYS-way set-associative, write-back, write-allocate cache with 4-word lines; per line: valid, dirty, tag, 128 data bits.
REQ-018 SHALL implement FSM states COMPARE, WRITEBACK, ALLOCATE, REFILL.
REQ-019 In COMPARE with a request, a hit (valid, tag match in any way) SHALL give proc_stall=0 in the same cycle; a read returns word proc_addr[1:0] combinationally; a write updates that word and sets dirty at the clock edge.
REQ-020 With no request, proc_stall SHALL be 0 and no state change occurs; proc_read and proc_write both high SHALL be treated as a write.
REQ-021 On a miss, the victim SHALL be the lowest-numbered invalid way, else the LRU way; victim dirty -> WRITEBACK, else -> ALLOCATE.
REQ-022 WRITEBACK SHALL drive mem_write=1, mem_addr={victim tag, index}, mem_wdata=victim line, held until mem_ready, then go to ALLOCATE.
REQ-023 ALLOCATE SHALL drive mem_read=1, mem_addr=proc_addr[29:2], held until mem_ready; mem_rdata SHALL be captured on that edge and the FSM goes to REFILL.
REQ-024 REFILL SHALL write the captured line to the victim way (valid=1, dirty=0, new tag) and return to COMPARE; the request then hits one cycle later, with a write miss merging as a write hit.
REQ-025 proc_stall SHALL be 1 in WRITEBACK, ALLOCATE and REFILL; mem_read, mem_write, mem_addr and mem_wdata SHALL be 0 outside their states.
REQ-026 Replacement SHALL be true LRU using per-set age ranks: on a completed hit the accessed way becomes rank 0 and ways with a lower rank increment; on REFILL the filled way becomes rank 0.
REQ-027 The processor SHALL hold request signals stable while proc_stall=1.
REQ-028 hit_cnt SHALL increment on each completed hit not preceded by a miss.
REQ-029 miss_cnt SHALL increment once per miss, on entry to WRITEBACK or ALLOCATE.
REQ-030 Both counters SHALL saturate at 16'hFFFF.
REQ-031 proc_rdata SHALL be 0 when no completed read is presented.

Reset
REQ-032 proc_reset SHALL immediately force state to COMPARE, clear all valid and dirty bits, set way w's rank to w in every set, and zero both counters.
REQ-033 Reset mid-transaction SHALL drop mem_read and mem_write asynchronously; dirty data is discarded.

Structure
REQ-034 A shared package cache_pkg SHALL hold the FSM state enumeration, LINE_W=128, WORDS_PER_LINE=4 and the address-width constants.
REQ-035 Replacement SHALL be a sub-module cache_lru: per-set rank storage, victim select and update.

Verification
REQ-036 Clean read miss (SETS=8, WAYS=2): read 30'h4 -> mem_read=1, mem_addr=28'h1; mem_ready with mem_rdata=128'hDDDD_CCCC_BBBB_AAAA_... -> two cycles later proc_stall=0, proc_rdata=word 0; miss_cnt=1.
REQ-037 Write hit then read: write 30'h4 with 32'hCAFEF00D -> proc_stall=0 same cycle; read 30'h4 -> 32'hCAFEF00D; hit_cnt increments by 2.
REQ-038 Conflict and LRU: fill 30'h4 and 30'h24 (same set 1), touch 30'h4, read 30'h44 -> way holding 30'h24 is evicted, a later read of 30'h4 hits.
REQ-039 Dirty eviction: dirty line at 30'h24 evicted -> mem_write=1, mem_addr=28'h9, mem_wdata contains the written word, then mem_read at 28'h11.
REQ-040 Reset during ALLOCATE with mem_ready low -> mem_read=0 immediately; a read of a prior hit address misses afterwards.
REQ-041 Counter saturation: force 65 540 hits -> hit_cnt=16'hFFFF.
